// File: rtl/line_capture_ctrl.sv
// Trigger-aligned ADC line capture into a single-entry valid/ready stream.
// Define LINE_HEADER_EN to prefix every line with a {4'hA, line_cnt[11:0]} word.
module line_capture_ctrl #(
  parameter int PIX_W = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk8m,
  input  logic             rst,
  input  logic             line_trig,
  input  logic [15:0]      delay_cfg,
  input  logic [11:0]      pix_num,
  input  logic [PIX_W-1:0] adc_data,
  input  logic             err_clr,
  output logic [15:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic [CNT_W-1:0] line_cnt,
  output logic             trig_miss,
  output logic             ovf_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DELAY   = 2'd1;
`ifdef LINE_HEADER_EN
  localparam logic [1:0] S_HEADER  = 2'd2;
`endif
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             r_trig_d;
  logic [15:0]      r_dly_cfg;
  logic [11:0]      r_pix_num;
  logic [15:0]      r_dly_cnt;
  logic [11:0]      r_pix_cnt;
  logic [CNT_W-1:0] r_line_cnt;
  logic [15:0]      r_data;
  logic             r_valid;
  logic             r_last;
  logic             r_miss;
  logic             r_ovf;

  logic             w_rise;
  logic             w_dly_done;
  logic             w_zero;
  logic             w_can_load;
  logic             w_cap;
  logic             w_hdr_ld;
  logic             w_last;
  logic             w_drop;
  logic             w_line_done;
  logic [15:0]      w_sample;
  logic [15:0]      w_hdr;

  assign w_rise     = line_trig & ~r_trig_d;
  assign w_dly_done = (r_state == S_DELAY) && (r_dly_cnt == r_dly_cfg);
  assign w_zero     = (r_pix_num == 12'd0);
  assign w_can_load = ~r_valid | m_ready;
  assign w_sample   = {{(16-PIX_W){1'b0}}, adc_data};

`ifdef LINE_HEADER_EN
  logic [11:0] w_hdr_cnt;
  if (CNT_W >= 12) begin : g_cnt_wide
    assign w_hdr_cnt = r_line_cnt[11:0];
  end else begin : g_cnt_narrow
    assign w_hdr_cnt = {{(12-CNT_W){1'b0}}, r_line_cnt};
  end
  assign w_hdr    = {4'hA, w_hdr_cnt};
  assign w_hdr_ld = (r_state == S_HEADER) && w_can_load;
  assign w_cap    = (r_state == S_CAPTURE);
`else
  assign w_hdr    = 16'h0000;
  assign w_hdr_ld = 1'b0;
  // Without a header the last DELAY cycle already samples pixel 0.
  assign w_cap    = (r_state == S_CAPTURE) | (w_dly_done & ~w_zero);
`endif

  assign w_last      = w_cap && (r_pix_cnt == r_pix_num - 12'd1);
  assign w_drop      = w_cap & ~w_can_load;
  assign w_line_done = w_last | (w_dly_done & w_zero);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) w_next = S_DELAY;
      end
      S_DELAY: begin
        if (w_line_done) w_next = S_IDLE;
`ifdef LINE_HEADER_EN
        else if (w_dly_done) w_next = S_HEADER;
`else
        else if (w_dly_done) w_next = S_CAPTURE;
`endif
      end
`ifdef LINE_HEADER_EN
      S_HEADER: begin
        if (w_can_load) w_next = S_CAPTURE;
      end
`endif
      S_CAPTURE: begin
        if (w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk8m) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_trig_d   <= 1'b0;
      r_dly_cfg  <= 16'd0;
      r_pix_num  <= 12'd0;
      r_dly_cnt  <= 16'd0;
      r_pix_cnt  <= 12'd0;
      r_line_cnt <= '0;
      r_data     <= 16'd0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_miss     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_trig_d <= line_trig;
      r_state  <= w_next;
      if ((r_state == S_IDLE) && w_rise) begin
        r_dly_cfg <= delay_cfg;
        r_pix_num <= pix_num;
        r_dly_cnt <= 16'd0;
        r_pix_cnt <= 12'd0;
      end else begin
        if (r_state == S_DELAY) r_dly_cnt <= r_dly_cnt + 16'd1;
        if (w_cap) r_pix_cnt <= r_pix_cnt + 12'd1;
      end
      if (w_line_done)
        r_line_cnt <= r_line_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_hdr_ld) begin
        r_data  <= w_hdr;
        r_last  <= 1'b0;
        r_valid <= 1'b1;
      end else if (w_cap && w_can_load) begin
        r_data  <= w_sample;
        r_last  <= w_last;
        r_valid <= 1'b1;
      end else if (m_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      // Setting events take priority over the clear pulse.
      if (w_rise && (r_state != S_IDLE)) r_miss <= 1'b1;
      else if (err_clr) r_miss <= 1'b0;
      if (w_drop) r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
    end
  end

  assign m_data    = r_data;
  assign m_valid   = r_valid;
  assign m_last    = r_last;
  assign busy      = (r_state != S_IDLE);
  assign line_cnt  = r_line_cnt;
  assign trig_miss = r_miss;
  assign ovf_err   = r_ovf;

endmodule

// File: tb/tb_line_capture_ctrl.sv
// Self-checking bench for line_capture_ctrl: random lines vs a stream model.
// Honours LINE_HEADER_EN the same way the design does.
module tb_line_capture_ctrl;

`ifdef LINE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        line_trig = 1'b0;
  logic        err_clr = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] delay_cfg = 16'd0;
  logic [11:0] pix_num = 12'd0;
  logic [11:0] adc_data;
  logic [15:0] m_data;
  logic        m_valid, m_last, busy, trig_miss, ovf_err;
  logic [15:0] line_cnt;

  logic        trig2 = 1'b0;
  logic        ready2 = 1'b0;
  logic [15:0] dly2 = 16'd0;
  logic [11:0] pix2 = 12'd0;
  logic [15:0] data2;
  logic        valid2, last2, busy2, miss2, ovf2;
  logic [11:0] cnt2;

  line_capture_ctrl #(.PIX_W(12), .CNT_W(16)) u_dut (
    .clk8m(clk), .rst(rst), .line_trig(line_trig),
    .delay_cfg(delay_cfg), .pix_num(pix_num),
    .adc_data(adc_data), .err_clr(err_clr),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .line_cnt(line_cnt),
    .trig_miss(trig_miss), .ovf_err(ovf_err)
  );

  line_capture_ctrl #(.PIX_W(12), .CNT_W(12)) u_wrap (
    .clk8m(clk), .rst(rst), .line_trig(trig2),
    .delay_cfg(dly2), .pix_num(pix2),
    .adc_data(adc_data), .err_clr(err_clr),
    .m_data(data2), .m_valid(valid2), .m_ready(ready2),
    .m_last(last2), .busy(busy2), .line_cnt(cnt2),
    .trig_miss(miss2), .ovf_err(ovf2)
  );

  logic [11:0] adc_tab [1024];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  assign adc_data = adc_tab[cyc[9:0]];

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  logic [15:0] got_d[$];
  bit          got_l[$];
  int          got_c[$];
  logic [15:0] exp_d[$];
  bit          exp_l[$];
  int          exp_c[$];

  bit          hold_p = 1'b0;
  logic [15:0] hold_d;
  logic        hold_l;

  // Stream monitor: records transfers, checks words stay put under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p) begin
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== hold_d || m_last !== hold_l) begin
          n_bad++;
          $display("FAIL hold_stable got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   m_valid, m_data, m_last, hold_d, hold_l);
        end
      end
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        got_c.push_back(cyc);
      end
      hold_p = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  function automatic logic [11:0] adc_at(input int c);
    return adc_tab[c[9:0]];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_q();
    got_d.delete(); got_l.delete(); got_c.delete();
    exp_d.delete(); exp_l.delete(); exp_c.delete();
  endtask

  // Rise in cycle t; pixel 0 sampled in cycle s; each word visible the cycle after load.
  task automatic model_line(input int t, input int d, input int n, input int cnt);
    int s;
    s = t + 1 + d + 2 * HDR;
    if (n == 0) return;
    if (HDR == 1) begin
      exp_d.push_back({4'hA, 12'(cnt)});
      exp_l.push_back(1'b0);
      exp_c.push_back(s);
    end
    for (int k = 0; k < n; k++) begin
      exp_d.push_back({4'h0, adc_at(s + k)});
      exp_l.push_back(k == n - 1);
      exp_c.push_back(s + 1 + k);
    end
  endtask

  task automatic fire(input int d, input int n, input int hold, output int t);
    line_trig = 1'b0;
    step();
    delay_cfg = 16'(d);
    pix_num = 12'(n);
    line_trig = 1'b1;
    t = cyc;
    for (int i = 1; i < hold; i++) step();
    step();
    line_trig = 1'b0;
  endtask

  task automatic wait_idle(input bit rr, input string tag);
    int i;
    i = 0;
    while (busy && i < 400) begin
      if (rr) m_ready = 1'($urandom_range(0, 1));
      step();
      i++;
    end
    n_vec++;
    if (busy) begin
      n_bad++;
      $display("FAIL %s idle_timeout busy=%b want 0", tag, busy);
    end
    m_ready = 1'b1;
    i = 0;
    while (m_valid && i < 20) begin
      step();
      i++;
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b want=0", m_valid); end
    n_vec++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rst_last got=%b want=0", m_last); end
    n_vec++; if (m_data !== 16'h0) begin n_bad++; $display("FAIL rst_data got=%h want=0000", m_data); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    n_vec++; if (line_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_cnt got=%0d want=0", line_cnt); end
    n_vec++; if (trig_miss !== 1'b0) begin n_bad++; $display("FAIL rst_miss got=%b want=0", trig_miss); end
    n_vec++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got=%b want=0", ovf_err); end
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    int t;
    clr_q();
    m_ready = 1'b1;
    fire(3, 4, 3, t);
    wait_idle(1'b0, "basic");
    model_line(t, 3, 4, exp_cnt);
    exp_cnt++;
    n_vec++;
    if (got_c.size() == 0 || got_c[0] != t + 5 + HDR) begin
      n_bad++;
      $display("FAIL basic_first_cycle got=%0d want=%0d", got_c.size() == 0 ? -1 : got_c[0] - t, 5 + HDR);
    end
    n_vec++;
    if (got_d.size() != exp_d.size()) begin
      n_bad++;
      $display("FAIL basic_words got=%0d want=%0d", got_d.size(), exp_d.size());
    end else begin
      foreach (exp_d[i]) begin
        n_vec++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || got_c[i] != exp_c[i]) begin
          n_bad++;
          $display("FAIL basic_word%0d got=%h/%b@%0d want=%h/%b@%0d", i,
                   got_d[i], got_l[i], got_c[i], exp_d[i], exp_l[i], exp_c[i]);
        end
      end
    end
    n_vec++;
    if (line_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL basic_cnt got=%0d want=%0d", line_cnt, exp_cnt); end
  endtask

  task automatic test_random();
    int t, d, n, h;
    m_ready = 1'b1;
    for (int l = 0; l < 12; l++) begin
      d = $urandom_range(0, 6);
      n = $urandom_range(0, 6);
      h = $urandom_range(1, 3);
      clr_q();
      fire(d, n, h, t);
      wait_idle(1'b0, "random");
      model_line(t, d, n, exp_cnt);
      exp_cnt++;
      n_vec++;
      if (got_d.size() != exp_d.size()) begin
        n_bad++;
        $display("FAIL rand%0d_words got=%0d want=%0d", l, got_d.size(), exp_d.size());
      end else begin
        foreach (exp_d[i]) begin
          n_vec++;
          if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || got_c[i] != exp_c[i]) begin
            n_bad++;
            $display("FAIL rand%0d_word%0d got=%h/%b@%0d want=%h/%b@%0d", l, i,
                     got_d[i], got_l[i], got_c[i], exp_d[i], exp_l[i], exp_c[i]);
          end
        end
      end
      n_vec++;
      if (line_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL rand%0d_cnt got=%0d want=%0d", l, line_cnt, exp_cnt); end
    end
  endtask

  task automatic test_backpressure();
    int t, i;
    logic [15:0] first;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    clr_q();
    m_ready = 1'b0;
    fire(2, 8, 2, t);
    i = 0;
    while (busy && i < 100) begin step(); i++; end
    n_vec++;
    if (busy) begin n_bad++; $display("FAIL bp_idle_timeout busy=%b want 0", busy); end
    first = (HDR == 1) ? {4'hA, 12'(exp_cnt)} : {4'h0, adc_at(t + 3)};
    exp_cnt++;
    n_vec++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid got=%b want=1", m_valid); end
    n_vec++; if (m_data !== first) begin n_bad++; $display("FAIL bp_data got=%h want=%h", m_data, first); end
    n_vec++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL bp_last got=%b want=0", m_last); end
    n_vec++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL bp_ovf got=%b want=1", ovf_err); end
    n_vec++; if (line_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL bp_cnt got=%0d want=%0d", line_cnt, exp_cnt); end
    n_vec++; if (got_d.size() != 0) begin n_bad++; $display("FAIL bp_early got=%0d want=0", got_d.size()); end
    m_ready = 1'b1;
    step(); step();
    n_vec++;
    if (got_d.size() != 1 || got_d[0] !== first || got_l[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_drain got_n=%0d want 1 word %h with last=0", got_d.size(), first);
    end
  endtask

  task automatic test_random_ready();
    int t, d, n, j, rcv;
    bit ok;
    for (int l = 0; l < 8; l++) begin
      d = $urandom_range(0, 3);
      n = $urandom_range(3, 8);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      clr_q();
      m_ready = 1'($urandom_range(0, 1));
      fire(d, n, 1, t);
      wait_idle(1'b1, "rdy");
      model_line(t, d, n, exp_cnt);
      exp_cnt++;
      ok = 1'b1;
      j = 0;
      foreach (got_d[i]) begin
        while (j < exp_d.size() && (exp_d[j] !== got_d[i] || exp_l[j] !== got_l[i])) j++;
        if (j >= exp_d.size()) ok = 1'b0;
        j++;
      end
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL rdy%0d_order got_n=%0d not an ordered subset of %0d words", l, got_d.size(), exp_d.size()); end
      rcv = got_d.size() - HDR;
      n_vec++;
      if (ovf_err !== 1'(rcv < n)) begin n_bad++; $display("FAIL rdy%0d_ovf got=%b want=%b (rcv %0d of %0d)", l, ovf_err, rcv < n, rcv, n); end
      n_vec++;
      if (line_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL rdy%0d_cnt got=%0d want=%0d", l, line_cnt, exp_cnt); end
    end
  endtask

  task automatic test_trig_miss();
    int t, last_c;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    clr_q();
    m_ready = 1'b1;
    line_trig = 1'b0; step();
    delay_cfg = 16'd20; pix_num = 12'd2;
    line_trig = 1'b1; t = cyc;
    step(); line_trig = 1'b0;
    step(); step(); step(); step();
    line_trig = 1'b1;
    step(); line_trig = 1'b0;
    wait_idle(1'b0, "miss");
    model_line(t, 20, 2, exp_cnt);
    exp_cnt++;
    n_vec++; if (trig_miss !== 1'b1) begin n_bad++; $display("FAIL miss_flag got=%b want=1", trig_miss); end
    n_vec++; if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL miss_words got=%0d want=%0d", got_d.size(), exp_d.size()); end
    n_vec++; if (line_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL miss_cnt got=%0d want=%0d", line_cnt, exp_cnt); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_vec++; if (trig_miss !== 1'b0) begin n_bad++; $display("FAIL miss_clr got=%b want=0", trig_miss); end
    clr_q();
    line_trig = 1'b0; step();
    delay_cfg = 16'd10; pix_num = 12'd2;
    line_trig = 1'b1;
    step(); line_trig = 1'b0;
    step(); step(); line_trig = 1'b1;
    step(); line_trig = 1'b0;
    step(); line_trig = 1'b1; err_clr = 1'b1;
    step(); line_trig = 1'b0; err_clr = 1'b0;
    n_vec++; if (trig_miss !== 1'b1) begin n_bad++; $display("FAIL miss_set_wins got=%b want=1", trig_miss); end
    wait_idle(1'b0, "miss2");
    exp_cnt++;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    clr_q();
    line_trig = 1'b0; step();
    delay_cfg = 16'd0; pix_num = 12'd3;
    line_trig = 1'b1; t = cyc;
    step(); line_trig = 1'b0;
    last_c = t + 3 + 2 * HDR;
    while (cyc < last_c) step();
    line_trig = 1'b1;
    step(); step(); step();
    n_vec++; if (trig_miss !== 1'b1) begin n_bad++; $display("FAIL end_rise_miss got=%b want=1", trig_miss); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL end_rise_busy got=%b want=0", busy); end
    line_trig = 1'b0;
    wait_idle(1'b0, "endrise");
    exp_cnt++;
    n_vec++; if (got_d.size() != 3 + HDR) begin n_bad++; $display("FAIL end_rise_words got=%0d want=%0d", got_d.size(), 3 + HDR); end
    n_vec++; if (line_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL end_rise_cnt got=%0d want=%0d", line_cnt, exp_cnt); end
  endtask

  task automatic test_reset_midline();
    int t, i;
    clr_q();
    m_ready = 1'b1;
    fire(1, 10, 1, t);
    i = 0;
    while (got_d.size() < 3 + HDR && i < 50) begin step(); i++; end
    n_vec++;
    if (got_d.size() < 3 + HDR) begin n_bad++; $display("FAIL mid_start got=%0d words want>=%0d", got_d.size(), 3 + HDR); end
    rst = 1'b1;
    step();
    n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got=%b want=0", m_valid); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    n_vec++; if (line_cnt !== 16'h0) begin n_bad++; $display("FAIL mid_cnt got=%0d want=0", line_cnt); end
    rst = 1'b0;
    exp_cnt = 0;
    clr_q();
    fire(1, 10, 2, t);
    wait_idle(1'b0, "mid");
    model_line(t, 1, 10, exp_cnt);
    exp_cnt++;
    n_vec++;
    if (got_d.size() != exp_d.size()) begin
      n_bad++;
      $display("FAIL mid_words got=%0d want=%0d", got_d.size(), exp_d.size());
    end else begin
      foreach (exp_d[k]) begin
        n_vec++;
        if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k] || got_c[k] != exp_c[k]) begin
          n_bad++;
          $display("FAIL mid_word%0d got=%h/%b@%0d want=%h/%b@%0d", k,
                   got_d[k], got_l[k], got_c[k], exp_d[k], exp_l[k], exp_c[k]);
        end
      end
    end
    n_vec++; if (line_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL mid_cnt2 got=%0d want=%0d", line_cnt, exp_cnt); end
  endtask

  task automatic test_wrap();
    int t, i;
    logic [15:0] w;
    dly2 = 16'd0;
    pix2 = 12'd0;
    trig2 = 1'b0;
    step();
    for (int l = 0; l < 4095; l++) begin
      trig2 = 1'b1; step();
      trig2 = 1'b0; step();
    end
    n_vec++; if (cnt2 !== 12'hFFF) begin n_bad++; $display("FAIL wrap_pre got=%h want=fff", cnt2); end
    ready2 = 1'b0;
    pix2 = 12'd1;
    trig2 = 1'b1; t = cyc;
    step(); trig2 = 1'b0;
    i = 0;
    while (busy2 && i < 30) begin step(); i++; end
    n_vec++; if (busy2) begin n_bad++; $display("FAIL wrap_idle_timeout busy=%b want 0", busy2); end
    w = (HDR == 1) ? 16'hAFFF : {4'h0, adc_at(t + 1)};
    n_vec++; if (cnt2 !== 12'h000) begin n_bad++; $display("FAIL wrap_cnt got=%h want=000", cnt2); end
    n_vec++; if (valid2 !== 1'b1) begin n_bad++; $display("FAIL wrap_valid got=%b want=1", valid2); end
    n_vec++; if (data2 !== w) begin n_bad++; $display("FAIL wrap_word got=%h want=%h", data2, w); end
    n_vec++; if (last2 !== 1'(HDR == 0)) begin n_bad++; $display("FAIL wrap_last got=%b want=%b", last2, HDR == 0); end
    n_vec++; if (ovf2 !== 1'(HDR == 1)) begin n_bad++; $display("FAIL wrap_ovf got=%b want=%b", ovf2, HDR == 1); end
    ready2 = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) adc_tab[i] = 12'($urandom);
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_random_ready();
    test_trig_miss();
    test_reset_midline();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
